aes_inv_round_ctrl: RTL

Iterative AES inverse-cipher core for the XTS block path. It accepts one 128-bit ciphertext block per valid/ready handshake and runs one decryption round per clock. Each round uses a single shared instance of each combinational inverse round function: InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. Round keys come from an external expanded-key store through a combinational index/data port. The plaintext is presented on a valid/ready output port with backpressure.

---
 rtl/aes_inv_round_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse cipher, one round per clock; outValid rises ROUNDS cycles after the input handshake.
// The result is held in DONE until outReady; no new block is accepted until it has been taken.
module aes_inv_round_ctrl #(
    parameter int ROUNDS = 14,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic [127:0]      inData,
    output logic [KIDX_W-1:0] keyIdx,
    input  logic [127:0]      keyData,
    output logic              outValid,
    input  logic              outReady,
    output logic [127:0]      outData
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [KIDX_W-1:0] RK    = KIDX_W'(ROUNDS);
    localparam logic [KIDX_W-1:0] RK_M1 = KIDX_W'(ROUNDS - 1);
    localparam logic [7:0]        INV_EXP = 8'hfe;

    state_t             state, nstate;
    logic [127:0]       st, st_nx;
    logic [KIDX_W-1:0]  rc, rc_nx;
    logic [127:0]       t, mc;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (INV_EXP[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    // Byte k = 4*col + row; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[127 - 32*c - 8  -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[127 - 32*c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[127 - 32*c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign t  = inv_shift_sub(st) ^ keyData;
    assign mc = inv_mix(t);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            rc    <= '0;
        end else begin
            state <= nstate;
            st    <= st_nx;
            rc    <= rc_nx;
        end
    end

    always_comb begin
        nstate = state;
        st_nx  = st;
        rc_nx  = rc;
        case (state)
            IDLE: begin
                if (inValid) begin
                    st_nx  = inData ^ keyData;
                    rc_nx  = RK_M1;
                    nstate = ROUND;
                end
            end
            ROUND: begin
                if (rc != '0) begin
                    st_nx = mc;
                    rc_nx = rc - KIDX_W'(1);
                end else begin
                    st_nx  = t;
                    nstate = DONE;
                end
            end
            DONE: begin
                if (outReady) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    assign inReady  = (state == IDLE);
    assign outValid = (state == DONE);
    assign keyIdx   = (state == ROUND) ? rc : RK;
    assign outData  = st;

endmodule
